// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the bus timeout controller
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR_RSP,
        DRAIN
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    typedef logic [1:0]  mst_idx_t;
    typedef logic [29:0] bus_addr_t;

    // Lowest-numbered master whose active-low grant is asserted.
    function automatic mst_idx_t lowest_grant(input logic [3:0] grntn);
        lowest_grant = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!grntn[i]) lowest_grant = mst_idx_t'(i);
        end
    endfunction

endpackage

// File: rtl/bus_timeout_ctrl_if.sv
// rtl/bus_timeout_ctrl_if.sv - observed bus strobes and injected return path
interface bus_timeout_ctrl_if;
    import bus_pkg::*;

    logic [3:0]  m_grntn;
    logic        s_asn;
    logic        s_rw;
    bus_addr_t   s_addr;
    logic [7:0]  s_csn;
    logic        slv_rdy;
    logic        to_rdy;
    logic [31:0] to_rdata;
    logic        rdy_mask;

    modport slave (
        input  m_grntn, s_asn, s_rw, s_addr, s_csn, slv_rdy,
        output to_rdy, to_rdata, rdy_mask
    );

    modport master (
        output m_grntn, s_asn, s_rw, s_addr, s_csn, slv_rdy,
        input  to_rdy, to_rdata, rdy_mask
    );
endinterface

// File: rtl/bus_err_log.sv
// rtl/bus_err_log.sv - sticky error log with overflow flag and saturating count
module bus_err_log
    import bus_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      log_en,
    input  logic      clr,
    input  mst_idx_t  cap_master,
    input  logic      cap_rw,
    input  bus_addr_t cap_addr,
    input  logic      cap_unmapped,
    output logic      err_valid,
    output logic      err_ovf,
    output logic      err_unmapped,
    output mst_idx_t  err_master,
    output logic      err_rw,
    output bus_addr_t err_addr,
    output logic [7:0] err_cnt
);

    logic [7:0] cnt_inc;
    assign cnt_inc = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_valid    <= 1'b0;
            err_ovf      <= 1'b0;
            err_unmapped <= 1'b0;
            err_master   <= '0;
            err_rw       <= 1'b0;
            err_addr     <= '0;
            err_cnt      <= '0;
        end else if (log_en) begin
            // A coincident clear empties the log first, so the new error becomes the first entry.
            if (err_valid && !clr) begin
                err_ovf <= 1'b1;
                err_cnt <= cnt_inc;
            end else begin
                err_valid    <= 1'b1;
                err_ovf      <= 1'b0;
                err_unmapped <= cap_unmapped;
                err_master   <= cap_master;
                err_rw       <= cap_rw;
                err_addr     <= cap_addr;
                err_cnt      <= clr ? 8'd1 : cnt_inc;
            end
        end else if (clr) begin
            err_valid    <= 1'b0;
            err_ovf      <= 1'b0;
            err_unmapped <= 1'b0;
            err_master   <= '0;
            err_rw       <= 1'b0;
            err_addr     <= '0;
            err_cnt      <= '0;
        end
    end

endmodule

// File: rtl/bus_timeout_ctrl.sv
// rtl/bus_timeout_ctrl.sv - bus transaction watchdog injecting error responses
module bus_timeout_ctrl
    import bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = BUS_ERR_DATA
) (
    input  logic               bus_clk,
    input  logic               bus_rstn,
    bus_timeout_ctrl_if.slave  bus,
    input  logic               err_clr,
    output logic               busy,
    output logic               err_valid,
    output logic               err_ovf,
    output logic               err_unmapped,
    output mst_idx_t           err_master,
    output logic               err_rw,
    output bus_addr_t          err_addr,
    output logic [7:0]         err_cnt
);

    localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    bus_state_t       state;
    logic [CNT_W-1:0] cnt;
    mst_idx_t         cap_master;
    logic             cap_rw;
    bus_addr_t        cap_addr;
    logic             cap_unmapped;
    logic             start;

    assign start = !bus.s_asn && (bus.m_grntn != 4'hF);

    always_ff @(posedge bus_clk or negedge bus_rstn) begin
        if (!bus_rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_master   <= '0;
            cap_rw       <= 1'b0;
            cap_addr     <= '0;
            cap_unmapped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_master   <= lowest_grant(bus.m_grntn);
                        cap_rw       <= bus.s_rw;
                        cap_addr     <= bus.s_addr;
                        cap_unmapped <= (bus.s_csn == 8'hFF);
                        if (bus.s_csn == 8'hFF) begin
                            state <= ERR_RSP;
                        end else if (!bus.slv_rdy) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (bus.slv_rdy || bus.s_asn) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= ERR_RSP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ERR_RSP: state <= DRAIN;
                DRAIN: begin
                    if (bus.s_asn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return-path controls come straight off the state flops so no input can glitch them.
    assign bus.to_rdy   = (state == ERR_RSP);
    assign bus.to_rdata = (state == ERR_RSP) ? ERR_DATA : 32'd0;
    assign bus.rdy_mask = (state == ERR_RSP) || (state == DRAIN);
    assign busy         = (state != IDLE);

    bus_err_log u_err_log (
        .clk          (bus_clk),
        .rstn         (bus_rstn),
        .log_en       (state == ERR_RSP),
        .clr          (err_clr),
        .cap_master   (cap_master),
        .cap_rw       (cap_rw),
        .cap_addr     (cap_addr),
        .cap_unmapped (cap_unmapped),
        .err_valid    (err_valid),
        .err_ovf      (err_ovf),
        .err_unmapped (err_unmapped),
        .err_master   (err_master),
        .err_rw       (err_rw),
        .err_addr     (err_addr),
        .err_cnt      (err_cnt)
    );

endmodule

// File: tb/tb_bus_timeout_ctrl.sv
// tb/tb_bus_timeout_ctrl.sv - directed and randomized checks against a transaction-level model
module tb_bus_timeout_ctrl;
    import bus_pkg::*;

    localparam int TO = 4;

    logic        bus_clk = 1'b0;
    logic        bus_rstn;
    logic        err_clr;
    logic        busy, err_valid, err_ovf, err_unmapped, err_rw;
    mst_idx_t    err_master;
    bus_addr_t   err_addr;
    logic [7:0]  err_cnt;

    int total = 0;
    int passed = 0;

    int          m_valid, m_ovf, m_unm, m_mst, m_rw, m_cnt;
    logic [29:0] m_addr;

    bus_timeout_ctrl_if bif ();

    bus_timeout_ctrl #(.TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .bus_clk      (bus_clk),
        .bus_rstn     (bus_rstn),
        .bus          (bif.slave),
        .err_clr      (err_clr),
        .busy         (busy),
        .err_valid    (err_valid),
        .err_ovf      (err_ovf),
        .err_unmapped (err_unmapped),
        .err_master   (err_master),
        .err_rw       (err_rw),
        .err_addr     (err_addr),
        .err_cnt      (err_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_valid = 0; m_ovf = 0; m_unm = 0; m_mst = 0; m_rw = 0; m_cnt = 0; m_addr = '0;
    endtask

    task automatic model_error(input int mst, input bit rw, input logic [29:0] addr,
                               input bit unm, input bit clr);
        if (clr) model_clear();
        if (m_valid == 0) begin
            m_valid = 1; m_mst = mst; m_rw = rw; m_addr = addr; m_unm = unm;
        end else begin
            m_ovf = 1;
        end
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    endtask

    task automatic chk_log();
        chk("err_valid", err_valid, m_valid[0]);
        chk("err_ovf", err_ovf, m_ovf[0]);
        chk("err_unmapped", err_unmapped, m_unm[0]);
        chk("err_master", err_master, m_mst[1:0]);
        chk("err_rw", err_rw, m_rw[0]);
        chk("err_addr", err_addr, m_addr);
        chk("err_cnt", err_cnt, m_cnt[7:0]);
    endtask

    task automatic bus_idle();
        bif.m_grntn = 4'hF; bif.s_asn = 1'b1; bif.s_rw = 1'b0; bif.s_addr = '0;
        bif.s_csn = 8'hFF; bif.slv_rdy = 1'b0; err_clr = 1'b0;
    endtask

    // One transaction starting now (1 time unit after a rising edge).
    // sl < 0: unmapped. kind 0: slave ready at cycle ra; 1: master abort at cycle ra; 2: timeout.
    // hold: extra cycles the master keeps the strobe after an error response.
    // late_off: slave ready offset from the error cycle (ignored by the DUT), -1 for none.
    task automatic txn(input int mst, input bit rw, input logic [29:0] addr, input int sl,
                       input int kind, input int ra, input int hold, input int late_off,
                       input bit clr);
        int err_c, last_low, end_busy, lr;
        logic [3:0] g;
        err_c = -1;
        if (sl < 0) err_c = 1;
        else if (kind == 2) err_c = TO + 1;
        if (err_c >= 0) begin
            last_low = err_c + hold; end_busy = last_low + 1;
        end else if (kind == 0) begin
            last_low = ra; end_busy = ra;
        end else begin
            last_low = ra - 1; end_busy = ra;
        end
        lr = (err_c >= 0 && late_off >= 0) ? err_c + (late_off % (hold + 2)) : -1;
        g = 4'(1 << mst);
        g = g | (4'($urandom) & ~4'((2 << mst) - 1));
        for (int c = 0; c <= last_low + 1; c++) begin
            bif.m_grntn = ~g;
            bif.s_asn   = (c <= last_low) ? 1'b0 : 1'b1;
            bif.s_rw    = rw;
            bif.s_addr  = addr;
            bif.s_csn   = (sl < 0) ? 8'hFF : ~(8'd1 << sl);
            bif.slv_rdy = (err_c < 0 && kind == 0 && c == ra) || (c == lr);
            err_clr     = clr && (c == err_c);
            @(negedge bus_clk);
            chk("to_rdy", bif.to_rdy, c == err_c);
            chk("to_rdata", bif.to_rdata, (c == err_c) ? 32'hDEAD_BEEF : 32'd0);
            chk("rdy_mask", bif.rdy_mask, err_c >= 0 && c >= err_c && c <= end_busy);
            chk("busy", busy, c >= 1 && c <= end_busy);
            if (c == err_c) model_error(mst, rw, addr, sl < 0, clr);
            @(posedge bus_clk); #1;
        end
        bus_idle();
        chk_log();
    endtask

    task automatic idle_clr();
        err_clr = 1'b1;
        @(posedge bus_clk); #1;
        err_clr = 1'b0;
        model_clear();
        chk_log();
    endtask

    task automatic ungranted_strobe();
        bif.s_asn = 1'b0; bif.m_grntn = 4'hF; bif.s_csn = 8'hFF;
        @(posedge bus_clk); #1;
        bus_idle();
        chk("ungranted_busy", busy, 1'b0);
        chk("ungranted_to_rdy", bif.to_rdy, 1'b0);
    endtask

    initial begin
        bus_rstn = 1'b0;
        bus_idle();
        model_clear();
        #12;
        chk("rst_to_rdy", bif.to_rdy, 1'b0);
        chk("rst_to_rdata", bif.to_rdata, 32'd0);
        chk("rst_rdy_mask", bif.rdy_mask, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk_log();
        @(posedge bus_clk); #1;
        bus_rstn = 1'b1;
        @(posedge bus_clk); #1;

        // Normal completion on the last WAIT cycle, then a timeout with a late slave ready.
        txn(1, 1'b1, 30'h100, 1, 0, TO, 0, -1, 1'b0);
        txn(1, 1'b1, 30'h100, 1, 2, 0, 2, 2, 1'b0);

        // Unmapped write from m3, then a second error that only sets overflow.
        idle_clr();
        txn(3, 1'b0, 30'h2A5, -1, 0, 0, 0, -1, 1'b0);
        txn(0, 1'b1, 30'h055, -1, 0, 0, 1, 0, 1'b0);

        // Master abort at cycle 2 of WAIT.
        txn(2, 1'b1, 30'h200, 3, 1, 2, 0, -1, 1'b0);

        // Asynchronous reset while draining an error response.
        bif.m_grntn = 4'b0111; bif.s_asn = 1'b0; bif.s_csn = 8'hFF; bif.s_rw = 1'b0;
        @(posedge bus_clk); #1;
        @(posedge bus_clk); #1;
        chk("drain_mask", bif.rdy_mask, 1'b1);
        bus_rstn = 1'b0;
        #1;
        model_clear();
        chk("rst_drain_busy", busy, 1'b0);
        chk("rst_drain_mask", bif.rdy_mask, 1'b0);
        chk("rst_drain_to_rdy", bif.to_rdy, 1'b0);
        chk_log();
        bus_idle();
        @(posedge bus_clk); #1;
        bus_rstn = 1'b1;
        @(posedge bus_clk); #1;
        txn(0, 1'b0, 30'h3C0, 5, 0, 3, 0, -1, 1'b0);

        // Clear coincident with a new error response.
        txn(1, 1'b0, 30'h111, 2, 2, 0, 0, -1, 1'b0);
        txn(2, 1'b0, 30'h3FF, -1, 0, 0, 1, -1, 1'b1);

        // Error counter saturation.
        idle_clr();
        for (int i = 0; i < 257; i++)
            txn(int'($urandom_range(3)), 1'($urandom), 30'($urandom), -1, 0, 0, 0, -1, 1'b0);
        chk("err_cnt_sat", err_cnt, 8'hFF);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            int kind;
            kind = int'($urandom_range(2));
            if ($urandom_range(9) == 0) idle_clr();
            if ($urandom_range(9) == 0) ungranted_strobe();
            txn(int'($urandom_range(3)), 1'($urandom), 30'($urandom),
                ($urandom_range(4) == 0) ? -1 : int'($urandom_range(7)),
                kind,
                (kind == 0) ? int'($urandom_range(TO)) : int'($urandom_range(TO, 1)),
                int'($urandom_range(3)),
                ($urandom_range(1) == 0) ? -1 : int'($urandom_range(7)),
                ($urandom_range(3) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bus_timeout_ctrl.md
# bus_timeout_ctrl

- Watches every transaction on the shared system bus and generates an error response when a slave never answers.
  - A transaction is never answered if the selected slave does not assert ready within a programmable number of cycles.
  - A transaction also gets an error response if its address decodes to no slave.
- Sits beside the arbiter, master mux, slave mux and address decoder in the bus top. It observes the granted master's strobes and the decoder's chip selects.
- It masks late slave ready and injects a one-cycle error ready plus error data into the master-side return path.
- It keeps a sticky error log for software.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max WAIT cycles before the error response; legal range 1..2^CNT_W-1.
- ERR_DATA, 32'hDEAD_BEEF: read data returned with an error response.
- CNT_W (localparam), $clog2(TIMEOUT_CYCLES+1): counter width.

Ports:
- bus_clk  in  1  bus clock; the single clock of the block.
- bus_rstn  in  1  reset; asynchronous, active-low.
- m_grntn  in  4  {m3_grntn..m0_grntn}, active-low grants from the arbiter.
- s_asn  in  1  muxed address strobe, active-low; held low until the cycle m_rdy is sampled high.
- s_rw  in  1  muxed direction: 1 = read, 0 = write.
- s_addr  in  30  muxed word address.
- s_csn  in  8  {s7_csn..s0_csn}, active-low chip selects from the decoder.
- slv_rdy  in  1  ready from the slave mux, before masking.
- err_clr  in  1  one-cycle pulse that clears the error log.
- to_rdy  out  1  injected ready. Bus top forms m_rdy = (slv_rdy & ~rdy_mask) | to_rdy.
- to_rdata  out  32  ERR_DATA while to_rdy = 1, else 0. Bus top selects it onto m_rdata when to_rdy = 1.
- rdy_mask  out  1  suppresses slv_rdy.
- busy  out  1  state != IDLE.
- err_valid  out  1  sticky: an error has been logged.
- err_ovf  out  1  sticky: an error occurred while err_valid was already 1.
- err_unmapped  out  1  logged error was an unmapped address (0 = timeout).
- err_master  out  2  index of the master in the logged error.
- err_rw  out  1  s_rw of the logged error.
- err_addr  out  30  s_addr of the logged error.
- err_cnt  out  8  error count, saturates at 255.

## Operation
States:
- IDLE (cnt = 0):
  - Transaction start is s_asn = 0 with at least one m_grntn bit low. s_asn = 0 with no grant is ignored.
  - At start, capture s_addr, s_rw and master. Master = index of the lowest low m_grntn bit.
  - If s_csn = 8'hFF, mark unmapped and go to ERR_RSP.
  - Else if slv_rdy = 1, stay in IDLE (zero-wait completion).
  - Else go to WAIT with cnt = 1.
- WAIT:
  - slv_rdy = 1: go to IDLE (normal completion).
  - Else s_asn = 1: master abort, go to IDLE with no error.
  - Else cnt == TIMEOUT_CYCLES: go to ERR_RSP (timeout).
  - Else cnt increments.
- ERR_RSP: to_rdy = 1 for exactly this cycle, to_rdata = ERR_DATA, and the log updates. Always go to DRAIN next.
- DRAIN: wait for s_asn = 1, then go to IDLE. Any slv_rdy seen here is discarded.

Error log, applied on the ERR_RSP cycle:
- If err_valid = 0: load err_master, err_rw, err_addr and err_unmapped from the captured values, and set err_valid.
- If err_valid = 1: keep the existing fields and set err_ovf.
- err_cnt increments, saturating at 255.
- err_clr zeroes err_valid, err_ovf, err_cnt and all fields.
- err_clr in the same cycle as an error: the clear applies first, then the new error logs. Result: err_valid = 1, err_ovf = 0, err_cnt = 1, new fields.

## Timing
- Reset (async, mid-transaction included): state = IDLE, cnt = 0, all outputs 0.
- to_rdy, rdy_mask and busy decode from state flops only; there is no combinational path from inputs to outputs.
- rdy_mask = 1 in ERR_RSP and DRAIN.
- Log outputs are registered and visible the cycle after ERR_RSP.
- Transaction start at cycle 0:
  - WAIT spans cycles 1..TIMEOUT_CYCLES.
  - slv_rdy at cycle TIMEOUT_CYCLES completes normally.
  - Otherwise to_rdy = 1 at cycle TIMEOUT_CYCLES+1.
- Unmapped start at cycle 0: to_rdy = 1 at cycle 1.
- Back-to-back transactions are only seen after s_asn has returned high for at least one cycle.
  - A new strobe in the IDLE cycle right after a normal completion is legal and starts tracking.

## Structure
- Shared package bus_pkg holds:
  - state enum {IDLE, WAIT, ERR_RSP, DRAIN};
  - BUS_ERR_DATA constant (parameter default);
  - master index typedef (logic [1:0]);
  - address typedef (logic [29:0]).
- One sub-module: bus_err_log. It holds the sticky log registers, ovf/saturation logic and err_clr priority. It is driven by a log_en pulse plus the captured fields.

## Test plan
- TIMEOUT_CYCLES = 4. m1 granted, read at 30'h100, s_csn = 8'hFD, slv_rdy at cycle 4 -> normal completion; to_rdy and rdy_mask never 1; err_valid = 0.
- Same setup, slv_rdy never asserted -> to_rdy = 1 only at cycle 5, to_rdata = 32'hDEAD_BEEF. Then err_valid = 1, err_master = 1, err_rw = 1, err_addr = 30'h100, err_unmapped = 0, err_cnt = 1.
- Continuing: slave asserts slv_rdy at cycle 7 while s_asn is still low -> rdy_mask = 1 blocks it; state returns to IDLE one cycle after s_asn goes high.
- m3 write, s_csn = 8'hFF -> to_rdy at cycle 1, err_unmapped = 1. A second error before err_clr -> err_ovf = 1, fields unchanged, err_cnt = 2.
- Master deasserts s_asn at cycle 2 of WAIT -> IDLE, no error. Separately, bus_rstn low during DRAIN -> all outputs 0 immediately, next transaction tracked normally.
- err_clr coincident with an ERR_RSP cycle -> err_valid = 1, err_ovf = 0, err_cnt = 1, fields from the new error. After 256 errors, err_cnt holds at 255.
